// File: rtl/enemy_hit_judge.sv
// Bullet/enemy collision judge: drives the explosion, hidden and respawn sequence and counts kills.
// Optional kill counter is built when ENEMY_HIT_SCORE_EN is defined; otherwise score is tied to zero.
module enemy_hit_judge #(
    parameter int ENEMY_W       = 50,
    parameter int ENEMY_H       = 50,
    parameter int BULLET_W      = 4,
    parameter int BULLET_H      = 8,
    parameter int BOOM_TICKS    = 255,
    parameter int RESPAWN_TICKS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_tick,
    input  logic        bullet_valid,
    input  logic [9:0]  bullet_x,
    input  logic [9:0]  bullet_y,
    input  logic [9:0]  enemy_x,
    input  logic [9:0]  enemy_y,
    input  logic        enemy_exist,
    output logic        boom,
    output logic        revive,
    output logic        hit_ack,
    output logic [15:0] score
);

    localparam logic [1:0] ALIVE  = 2'd0;
    localparam logic [1:0] HIT    = 2'd1;
    localparam logic [1:0] DEAD   = 2'd2;
    localparam logic [1:0] REVIVE = 2'd3;

    localparam logic [10:0] EW = 11'(ENEMY_W);
    localparam logic [10:0] EH = 11'(ENEMY_H);
    localparam logic [10:0] BW = 11'(BULLET_W);
    localparam logic [10:0] BH = 11'(BULLET_H);

    localparam logic [7:0] BOOM_LAST    = 8'(BOOM_TICKS - 1);
    localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_TICKS - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [10:0] bx, by, ex, ey;
    logic        overlap;
    logic        hit_now;

    // 11-bit operands so that box edges past pixel 1023 do not wrap around
    assign bx = {1'b0, bullet_x};
    assign by = {1'b0, bullet_y};
    assign ex = {1'b0, enemy_x};
    assign ey = {1'b0, enemy_y};

    assign overlap = (bx < ex + EW) && (ex < bx + BW) &&
                     (by < ey + EH) && (ey < by + BH);

    assign hit_now = (state == ALIVE) && bullet_valid && enemy_exist && overlap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ALIVE;
            cnt     <= '0;
            boom    <= 1'b0;
            revive  <= 1'b0;
            hit_ack <= 1'b0;
        end else begin
            hit_ack <= 1'b0;
            case (state)
                ALIVE: begin
                    boom   <= 1'b0;
                    revive <= 1'b0;
                    if (hit_now) begin
                        state   <= HIT;
                        cnt     <= '0;
                        boom    <= 1'b1;
                        hit_ack <= 1'b1;
                    end
                end
                HIT: begin
                    if (move_tick) begin
                        if (cnt == BOOM_LAST) begin
                            state <= DEAD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                DEAD: begin
                    if (move_tick) begin
                        if (cnt == RESPAWN_LAST) begin
                            state  <= REVIVE;
                            cnt    <= '0;
                            boom   <= 1'b0;
                            revive <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                REVIVE: begin
                    // revive held across two move ticks: enemy clears explosion, then reloads position
                    if (move_tick) begin
                        if (cnt == 8'd1) begin
                            state  <= ALIVE;
                            cnt    <= '0;
                            revive <= 1'b0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state  <= ALIVE;
                    cnt    <= '0;
                    boom   <= 1'b0;
                    revive <= 1'b0;
                end
            endcase
        end
    end

`ifdef ENEMY_HIT_SCORE_EN
    logic [15:0] score_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q <= '0;
        end else if (hit_now && (score_q != 16'hFFFF)) begin
            score_q <= score_q + 16'd1;
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_enemy_hit_judge.sv
// Scoreboard bench for enemy_hit_judge: a tick-count reference model queues expected outputs per cycle.
module tb_enemy_hit_judge;

    localparam int EW = 50, EH = 50, BW = 4, BH = 8;
    localparam int BOOM_N = 255, RESP_N = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_tick, bullet_valid, enemy_exist;
    logic [9:0]  bullet_x, bullet_y, enemy_x, enemy_y;
    logic        boom, revive, hit_ack;
    logic [15:0] score;

    enemy_hit_judge #(
        .ENEMY_W(EW), .ENEMY_H(EH), .BULLET_W(BW), .BULLET_H(BH),
        .BOOM_TICKS(BOOM_N), .RESPAWN_TICKS(RESP_N)
    ) dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .bullet_valid(bullet_valid),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .enemy_x(enemy_x), .enemy_y(enemy_y),
        .enemy_exist(enemy_exist), .boom(boom), .revive(revive), .hit_ack(hit_ack),
        .score(score)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        boom;
        logic        revive;
        logic        ack;
        logic [15:0] score;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model: total move ticks since the kill decide the phase
    bit   m_hit = 0;
    int   m_ticks = 0;
    bit   m_ack = 0;
    int   m_score = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit model_overlap();
        int bx = int'(bullet_x), by = int'(bullet_y);
        int ex = int'(enemy_x), ey = int'(enemy_y);
        return (bx < ex + EW) && (ex < bx + BW) && (by < ey + EH) && (ey < by + BH);
    endfunction

    task automatic model_reset();
        m_hit = 0; m_ticks = 0; m_ack = 0; m_score = 0;
    endtask

    task automatic step(input logic mt, input logic bv, input logic exist);
        exp_t e;
        move_tick = mt; bullet_valid = bv; enemy_exist = exist;
        m_ack = 0;
        if (!m_hit) begin
            if (bv && exist && model_overlap()) begin
                m_hit = 1; m_ticks = 0; m_ack = 1;
`ifdef ENEMY_HIT_SCORE_EN
                if (m_score < 65535) m_score++;
`endif
            end
        end else begin
            if (mt) m_ticks++;
            if (m_ticks == BOOM_N + RESP_N + 2) begin
                m_hit = 0; m_ticks = 0;
            end
        end
        e.boom   = m_hit && (m_ticks < BOOM_N + RESP_N);
        e.revive = m_hit && (m_ticks >= BOOM_N + RESP_N);
        e.ack    = m_ack;
        e.score  = 16'(m_score);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("boom", 32'(boom), 32'(e.boom));
        check("revive", 32'(revive), 32'(e.revive));
        check("hit_ack", 32'(hit_ack), 32'(e.ack));
        check("score", 32'(score), 32'(e.score));
        check("exclusive", 32'(boom && revive), 32'd0);
    endtask

    task automatic place(input int bx, input int by, input int ex, input int ey);
        bullet_x = 10'(bx); bullet_y = 10'(by); enemy_x = 10'(ex); enemy_y = 10'(ey);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_boom"}, 32'(boom), 32'd0);
        check({tag, "_revive"}, 32'(revive), 32'd0);
        check({tag, "_ack"}, 32'(hit_ack), 32'd0);
        check({tag, "_score"}, 32'(score), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        move_tick = 1'b0; bullet_valid = 1'b0; enemy_exist = 1'b0;
        place(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        model_reset();

        // Boundaries and ignored cases while alive
        place(145, 200, 95, 180); step(1'b0, 1'b1, 1'b1);
        place(91, 200, 95, 180);  step(1'b0, 1'b1, 1'b1);
        place(100, 230, 95, 180); step(1'b1, 1'b1, 1'b1);
        place(100, 172, 95, 180); step(1'b0, 1'b1, 1'b1);
        place(1020, 1020, 990, 990); step(1'b0, 1'b0, 1'b1);
        place(100, 200, 95, 180); step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        place(92, 173, 95, 180);  step(1'b0, 1'b0, 1'b1);

        // Right-edge hit, then full sequence with a bullet overlapping throughout
        place(144, 200, 95, 180); step(1'b1, 1'b1, 1'b1);
        place(100, 200, 95, 180);
        for (int i = 0; i < 700; i++) step(1'(i % 2 == 0), 1'b1, 1'b1);

        // Clean restart, hit, then reset 10 ticks into the hidden phase
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        check_zero("rst_hit");
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < BOOM_N + 10; i++) step(1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_dead");
        model_reset();
        #1;
        rst = 1'b0;
        for (int i = 0; i < RESP_N + 10; i++) step(1'b1, 1'b0, 1'b0);

        // Fresh hit after reset proves the counter restarted from zero
        place(100, 200, 95, 180);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < BOOM_N + RESP_N + 4; i++) step(1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/enemy_hit_judge.md
ENEMY_HIT_JUDGE -- requirements
Module: enemy_hit_judge

Interface
REQ-001 Parameter ENEMY_W, default 50, enemy sprite width in pixels.
REQ-002 Parameter ENEMY_H, default 50, enemy sprite height in pixels.
REQ-003 Parameter BULLET_W, default 4, and BULLET_H, default 8, bullet box size in pixels.
REQ-004 Parameter BOOM_TICKS, default 255, move ticks the explosion is shown.
REQ-005 Parameter RESPAWN_TICKS, default 64, move ticks the enemy stays hidden after the explosion.
REQ-006 clk  in  1  system clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 move_tick  in  1  one-clk pulse per movement step; used as a synchronous enable, not as a clock.
REQ-009 bullet_valid  in  1  a live bullet is present at bullet_x/bullet_y.
REQ-010 bullet_x, bullet_y  in  10 each  bullet top-left pixel.
REQ-011 enemy_x, enemy_y  in  10 each  enemy top-left pixel.
REQ-012 enemy_exist  in  1  high while the enemy is alive and not exploding.
REQ-013 boom  out  1  explosion/kill request to the enemy block; level signal.
REQ-014 revive  out  1  respawn request to the enemy block; level signal.
REQ-015 hit_ack  out  1  one-clk pulse telling the bullet owner to retire the bullet.
REQ-016 score  out  16  count of kills.

Function
REQ-017 The overlap test SHALL be computed on 11-bit zero-extended values: bx < ex+ENEMY_W, ex < bx+BULLET_W, by < ey+ENEMY_H, and ey < by+BULLET_H, where bx/by are bullet_x/bullet_y and ex/ey are enemy_x/enemy_y; no wrap at 1023.
REQ-018 FSM states SHALL be ALIVE, HIT, DEAD and REVIVE; the reset state SHALL be ALIVE.
REQ-019 ALIVE: boom=0 and revive=0; the FSM SHALL go to HIT when bullet_valid, enemy_exist and overlap are all high on a clk edge.
REQ-020 ALIVE: a hit SHALL be captured regardless of move_tick.
REQ-021 On the ALIVE->HIT edge: hit_ack=1 for exactly that one following cycle; boom=1 from that cycle on; tick counter cleared to 0.
REQ-022 HIT: the counter SHALL increment on each move_tick.
REQ-023 HIT: when the counter equals BOOM_TICKS-1 and move_tick is high, the FSM SHALL go to DEAD and clear the counter.
REQ-024 DEAD: boom SHALL stay 1 and the counter SHALL increment on move_tick.
REQ-025 DEAD: when the counter equals RESPAWN_TICKS-1 and move_tick is high, the FSM SHALL go to REVIVE and clear the counter.
REQ-026 REVIVE: boom=0 and revive=1 while the FSM stays in this state.
REQ-027 REVIVE: the FSM SHALL return to ALIVE after the 2nd move_tick.
REQ-028 Holding revive for two move ticks is required: the enemy's explosion counter clears on the first tick and its position reloads on the second.
REQ-029 Collisions in HIT, DEAD or REVIVE SHALL be ignored: no hit_ack and no score change.
REQ-030 bullet_valid with enemy_exist=0 in ALIVE SHALL be ignored.
REQ-031 The tick counter SHALL be 8 bits wide; parameters above 256 are unsupported.
REQ-032 boom, revive and hit_ack SHALL be registered outputs; boom and revive SHALL never both be 1.

Reset
REQ-033 On rst: state=ALIVE, counter=0, boom=0, revive=0, hit_ack=0, score=0, all immediately and asynchronously.
REQ-034 Reset mid-HIT/DEAD/REVIVE SHALL abandon the sequence; no revive pulse is issued afterwards.

Configuration
REQ-035 Macro ENEMY_HIT_SCORE_EN defined: score SHALL increment by 1 on each ALIVE->HIT transition, in the same cycle hit_ack rises, and saturate at 16'hFFFF.
REQ-036 Macro ENEMY_HIT_SCORE_EN undefined: no score register is built; score SHALL be tied to 16'h0000.

Verification
REQ-037 Bullet (100,200), enemy (95,180), valid and exist high -> next cycle hit_ack=1 for 1 clk, boom=1, score=1.
REQ-038 Bullet (145,200), enemy (95,180) (bx = ex+ENEMY_W) -> no hit; bullet (144,200) -> hit.
REQ-039 Hit, then 255 move_ticks, then 64 move_ticks -> boom falls and revive rises on the 319th tick; revive falls and state=ALIVE on the 2nd following tick.
REQ-040 Second overlapping bullet presented during HIT -> no hit_ack, score unchanged.
REQ-041 rst asserted 10 ticks into DEAD -> boom=0 and revive=0 immediately; no revive afterwards; score=0.
REQ-042 Build without ENEMY_HIT_SCORE_EN, run REQ-037 stimulus -> score=0, boom and hit_ack unchanged.
